// File: rtl/icache_dm.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | icache_dm : direct-mapped instruction cache, 32-byte lines, block refill |
// | Revision  : 1.0                                                          |
// +-------------------------------------------------------------------------+
module icache_dm #(
   parameter int NUM_LINES  = 64,
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  Read_2IC,
   input  logic [ADDR_WIDTH-1:0] Instr_address_2IC,
   input  logic                  Invalidate_2IC,
   output logic [31:0]           Instr1_fIC,
   output logic [31:0]           Instr2_fIC,
   output logic                  Instr1_valid_fIC,
   output logic                  Instr2_valid_fIC,
   output logic                  STALL_fIC,
   output logic [ADDR_WIDTH-1:0] Instr_address_2IM,
   output logic                  iBlkRead,
   input  logic [255:0]          block_read_fIM,
   input  logic                  block_read_fIM_valid,
   output logic [CNT_WIDTH-1:0]  Hit_count,
   output logic [CNT_WIDTH-1:0]  Miss_count
);

   localparam int IDX = $clog2(NUM_LINES);
   localparam int TAG = ADDR_WIDTH - 5 - IDX;
   localparam int LW  = ADDR_WIDTH - 5;

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_REFILL = 1'b1} state_t;

   state_t                 state_q, state_d;
   logic                   blk_q, blk_d;
   logic [LW-1:0]          line_q, line_d;
   logic [CNT_WIDTH-1:0]   hit_q, hit_d;
   logic [CNT_WIDTH-1:0]   miss_q, miss_d;
   logic [NUM_LINES-1:0]   valid_q, valid_d;
   logic                   fill_en;

   logic [255:0]           data_q [NUM_LINES];
   logic [TAG-1:0]         tag_q  [NUM_LINES];

   logic [2:0]             w_off;
   logic [IDX-1:0]         w_idx;
   logic [TAG-1:0]         w_tag;
   logic [255:0]           w_line;
   logic                   w_hit;
   logic [IDX-1:0]         fill_idx;
   logic [TAG-1:0]         fill_tag;
   logic                   unused_ok;

   assign w_off    = Instr_address_2IC[4:2];
   assign w_idx    = Instr_address_2IC[4+IDX:5];
   assign w_tag    = Instr_address_2IC[ADDR_WIDTH-1:5+IDX];
   assign w_line   = data_q[w_idx];
   assign w_hit    = valid_q[w_idx] && (tag_q[w_idx] == w_tag) && (state_q == S_IDLE);
   assign fill_idx = line_q[IDX-1:0];
   assign fill_tag = line_q[LW-1:IDX];
   assign unused_ok = ^Instr_address_2IC[1:0];

   assign Instr1_valid_fIC  = w_hit;
   assign Instr2_valid_fIC  = w_hit && (w_off != 3'd7);
   assign Instr1_fIC        = w_hit ? w_line[{w_off, 5'b0} +: 32] : 32'd0;
   assign Instr2_fIC        = Instr2_valid_fIC ? w_line[{w_off + 3'd1, 5'b0} +: 32] : 32'd0;
   assign STALL_fIC         = Read_2IC && !w_hit;
   assign iBlkRead          = blk_q;
   assign Instr_address_2IM = {line_q, 5'b0};
   assign Hit_count         = hit_q;
   assign Miss_count        = miss_q;

   always_comb begin
      state_d = state_q;
      blk_d   = blk_q;
      line_d  = line_q;
      hit_d   = hit_q;
      miss_d  = miss_q;
      valid_d = valid_q;
      fill_en = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (Read_2IC && !w_hit && !Invalidate_2IC) begin
               state_d = S_REFILL;
               blk_d   = 1'b1;
               line_d  = Instr_address_2IC[ADDR_WIDTH-1:5];
               if (miss_q != '1) miss_d = miss_q + CNT_WIDTH'(1);
            end
         end
         default: begin
            // An invalidate wins over arriving data so a flushed line never lands.
            if (Invalidate_2IC) begin
               state_d = S_IDLE;
               blk_d   = 1'b0;
            end else if (block_read_fIM_valid) begin
               fill_en           = 1'b1;
               valid_d[fill_idx] = 1'b1;
               state_d           = S_IDLE;
               blk_d             = 1'b0;
            end
         end
      endcase
      if (Invalidate_2IC) valid_d = '0;
      if (Read_2IC && w_hit && (hit_q != '1)) hit_d = hit_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= S_IDLE;
         blk_q   <= 1'b0;
         line_q  <= '0;
         hit_q   <= '0;
         miss_q  <= '0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         blk_q   <= blk_d;
         line_q  <= line_d;
         hit_q   <= hit_d;
         miss_q  <= miss_d;
         valid_q <= valid_d;
      end
   end

   // Line storage carries no reset; the valid bits alone qualify it.
   always_ff @(posedge CLK) begin
      if (fill_en) begin
         data_q[fill_idx] <= block_read_fIM;
         tag_q[fill_idx]  <= fill_tag;
      end
   end

endmodule
`default_nettype wire
